// File: rtl/lcd_frame_scheduler.sv
// Frame scheduler for the dual-controller 128x64 LCD driver: periodic/forced start strobes,
// end-of-frame detection, watchdog and graphic-RAM double-buffer swap. Optional LCD_FRAME_STATS_EN.
module lcd_frame_scheduler #(
    parameter int REFRESH_DIV = 2_000_000,
    parameter int START_PULSE = 4,
    parameter int TIMEOUT     = 8192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       force_i,
    input  logic       rnd_done_i,
    output logic       rnd_ready_o,
    output logic       buf_sel_o,
    output logic       drv_start_o,
    input  logic [9:0] drv_addr_i,
    output logic       busy_o,
    output logic [7:0] frame_cnt_o,
    output logic       timeout_o,
    output logic [7:0] drop_cnt_o
);

    localparam int TW = $clog2(REFRESH_DIV);
    localparam int WW = $clog2(TIMEOUT);
    localparam int PW = $clog2(START_PULSE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [TW-1:0] r_timer;
    logic          r_frame_req;
    logic          r_swap_pend;
    logic          r_rnd_ready;
    logic          r_buf_sel;
    logic          r_drv_start;
    logic          r_busy;
    logic [PW-1:0] r_pcnt;
    logic [WW-1:0] r_wdog;
    logic [9:0]    r_addr_prev;
    logic [7:0]    r_frame_cnt;
    logic          r_timeout;

    logic w_tick;
    logic w_req_in;
    logic w_start;
    logic w_pulse_end;
    logic w_frame_done;
    logic w_wd_expire;

    assign w_tick       = en_i && (r_timer == TW'(REFRESH_DIV - 1));
    assign w_req_in     = w_tick || force_i;
    assign w_start      = (r_state == S_IDLE) && r_frame_req;
    assign w_pulse_end  = (r_state == S_PULSE) && (r_pcnt == PW'(START_PULSE - 1));
    // End of frame is the wrap of the driver's address from the last cell back to zero.
    assign w_frame_done = (r_state == S_WAIT) && (r_addr_prev == 10'h3FF) && (drv_addr_i == 10'h000);
    assign w_wd_expire  = (r_state == S_WAIT) && !w_frame_done && (r_wdog == WW'(TIMEOUT - 1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (r_frame_req) w_state_next = S_PULSE;
            S_PULSE: if (w_pulse_end) w_state_next = S_WAIT;
            S_WAIT:  if (w_frame_done || w_wd_expire) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
        end
    end

    // Single-level request: anything arriving while one is pending merges into it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer     <= '0;
            r_frame_req <= 1'b0;
        end else begin
            if (!en_i || w_tick)
                r_timer <= '0;
            else
                r_timer <= r_timer + TW'(1);

            if (w_start)
                r_frame_req <= 1'b0;
            else if (w_req_in)
                r_frame_req <= 1'b1;
        end
    end

    // Swap only on the frame-start edge so the driver never sees the buffer change mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_swap_pend <= 1'b0;
            r_rnd_ready <= 1'b1;
            r_buf_sel   <= 1'b0;
        end else if (w_start && r_swap_pend) begin
            r_buf_sel   <= ~r_buf_sel;
            r_swap_pend <= 1'b0;
            r_rnd_ready <= 1'b1;
        end else if (rnd_done_i && r_rnd_ready) begin
            r_swap_pend <= 1'b1;
            r_rnd_ready <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drv_start <= 1'b0;
            r_pcnt      <= '0;
            r_wdog      <= '0;
            r_addr_prev <= '0;
            r_frame_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_drv_start <= 1'b1;
                        r_pcnt      <= '0;
                    end
                end
                S_PULSE: begin
                    r_pcnt      <= r_pcnt + PW'(1);
                    r_wdog      <= '0;
                    r_addr_prev <= '0;
                    if (w_pulse_end)
                        r_drv_start <= 1'b0;
                end
                S_WAIT: begin
                    r_addr_prev <= drv_addr_i;
                    r_wdog      <= r_wdog + WW'(1);
                    if (w_frame_done)
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                    if (w_wd_expire)
                        r_timeout <= 1'b1;
                end
                default: r_drv_start <= 1'b0;
            endcase
        end
    end

`ifdef LCD_FRAME_STATS_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_drop_cnt <= 8'd0;
        else if (w_req_in && r_frame_req && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 8'd1;
    end

    assign drop_cnt_o = r_drop_cnt;
`else
    assign drop_cnt_o = 8'd0;
`endif

    assign rnd_ready_o = r_rnd_ready;
    assign buf_sel_o   = r_buf_sel;
    assign drv_start_o = r_drv_start;
    assign busy_o      = r_busy;
    assign frame_cnt_o = r_frame_cnt;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Randomized bench for lcd_frame_scheduler with an LCD driver model and a timeline-based
// reference model; compares every output every cycle.
module tb_lcd_frame_scheduler;

    localparam int RD  = 100;
    localparam int SP  = 4;
    localparam int TO  = 3000;

    logic       clk;
    logic       rst;
    logic       en;
    logic       force_in;
    logic       done_in;
    logic       rnd_ready;
    logic       buf_sel;
    logic       drv_start;
    logic [9:0] drv_addr;
    logic       busy;
    logic [7:0] frame_cnt;
    logic       timeout;
    logic [7:0] drop_cnt;

    lcd_frame_scheduler #(.REFRESH_DIV(RD), .START_PULSE(SP), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .force_i     (force_in),
        .rnd_done_i  (done_in),
        .rnd_ready_o (rnd_ready),
        .buf_sel_o   (buf_sel),
        .drv_start_o (drv_start),
        .drv_addr_i  (drv_addr),
        .busy_o      (busy),
        .frame_cnt_o (frame_cnt),
        .timeout_o   (timeout),
        .drop_cnt_o  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: m_t is cycles since the frame-start edge (-1 when idle).
    int m_t, m_timer, m_frames, m_drops;
    bit m_req, m_pend, m_buf, m_timeout;
    logic [9:0] m_prev;

    // LCD driver model
    bit d_walking, d_st_prev, stall;
    int d_sub;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_t = -1; m_timer = 0; m_frames = 0; m_drops = 0;
        m_req = 0; m_pend = 0; m_buf = 0; m_timeout = 0; m_prev = '0;
        d_walking = 0; d_st_prev = 0; d_sub = 0; drv_addr = '0;
    endtask

    task automatic model_edge();
        bit tick, req_in, pend0, req0;
        tick   = en && (m_timer == RD - 1);
        req_in = tick || force_in;
        pend0  = m_pend;
        req0   = m_req;
        m_timer = (en && !tick) ? m_timer + 1 : 0;
        if (req_in && req0 && m_drops < 255) m_drops++;
        if (m_t < 0) begin
            if (req0) begin
                m_t = 0;
                if (pend0) begin m_buf = !m_buf; m_pend = 0; end
            end
        end else if (m_t < SP) begin
            m_t++;
        end else if (m_t >= SP + 1 && m_prev == 10'h3FF && drv_addr == 10'h000) begin
            m_t = -1; m_frames++;
        end else if (m_t == SP - 1 + TO) begin
            m_t = -1; m_timeout = 1;
        end else begin
            m_t++;
        end
        if (done_in && !pend0) m_pend = 1;
        m_req  = (m_t == 0 && req0 && !(m_t < 0)) ? (req0 && m_t != 0) : (req_in ? 1'b1 : req0);
        m_prev = drv_addr;
    endtask

    task automatic check_all();
        int exp_drop;
`ifdef LCD_FRAME_STATS_EN
        exp_drop = m_drops;
`else
        exp_drop = 0;
`endif
        chk("drv_start", drv_start, (m_t >= 0 && m_t < SP));
        chk("busy",      busy,      (m_t >= 0));
        chk("buf_sel",   buf_sel,   m_buf);
        chk("rnd_ready", rnd_ready, !m_pend);
        chk("frame_cnt", frame_cnt, m_frames % 256);
        chk("timeout",   timeout,   m_timeout);
        chk("drop_cnt",  drop_cnt,  exp_drop);
    endtask

    task automatic drive_addr();
        if (d_st_prev && !drv_start) begin
            d_walking = 1; drv_addr = '0; d_sub = 1;
        end else if (d_walking && !(stall && drv_addr == 10'h123)) begin
            d_sub++;
            if (d_sub == 2) begin
                d_sub = 0;
                if (drv_addr == 10'h3FF) begin drv_addr = '0; d_walking = 0; end
                else drv_addr = drv_addr + 10'd1;
            end
        end
        d_st_prev = drv_start;
    endtask

    // One clock: model sees the inputs the DUT sampled, outputs are compared 1 unit later.
    task automatic step();
        bit started;
        @(posedge clk);
        started = (m_t < 0) && m_req;
        model_edge();
        if (started) m_req = 0;
        cyc++;
        #1;
        check_all();
        drive_addr();
        force_in = 0;
        done_in  = 0;
    endtask

    initial begin
        bit hit;
        rst = 1; en = 0; force_in = 0; done_in = 0; stall = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 0;

        // Periodic refresh with random forces and renderer completions.
        en = 1;
        for (int c = 0; c < 14000; c++) begin
            force_in = ($urandom_range(0, 999) == 0);
            done_in  = (c == 10) || ($urandom_range(0, 1499) == 0);
            step();
        end

        // Driver stalls mid-frame: watchdog must abort.
        stall = 1;
        hit = 0;
        for (int c = 0; c < 12000 && !hit; c++) begin
            step();
            hit = m_timeout;
        end
        chk("timeout_reached", timeout, 1);
        stall = 0;

        // Timer off: forced frames only, three forces within one frame.
        en = 0;
        for (int c = 0; c < 6000; c++) begin
            force_in = (c == 5) || (c == 500) || (c == 700) || (c == 900) ||
                       (c > 4500 && $urandom_range(0, 499) == 0);
            done_in  = ($urandom_range(0, 799) == 0);
            step();
        end

        // Async reset while the start strobe is high and the front buffer is 1.
        en = 1;
        hit = 0;
        for (int c = 0; c < 10000 && !hit; c++) begin
            done_in = 1;
            step();
            hit = (m_t == 1) && m_buf;
        end
        chk("pulse_found", {31'd0, hit}, 1);
        rst = 1;
        #1;
        chk("rst_drv_start", drv_start, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_buf_sel",   buf_sel,   0);
        chk("rst_rnd_ready", rnd_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
        for (int c = 0; c < 400; c++) begin
            done_in = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
